// File: rtl/multi_pulser_if.sv
// Button/pulse bundle between the board push-buttons and multi_pulser.
// The design side uses the slave modport; the stimulus side uses master.
interface multi_pulser_if #(
  parameter int N = 4
);
  logic [N-1:0] btn;
  logic [N-1:0] repeat_en;
  logic [N-1:0] pulse;
  logic [N-1:0] held;
  logic         any_pulse;

  modport master (output btn, output repeat_en, input pulse, input held, input any_pulse);
  modport slave  (input btn, input repeat_en, output pulse, output held, output any_pulse);
endinterface

// File: rtl/multi_pulser.sv
// N-channel debounced one-pulser with optional per-channel auto-repeat.
// Each channel: 2-flop synchroniser feeding an independent press/hold FSM.
module multi_pulser_chan #(
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic repeat_en,
  output logic pulse,
  output logic held
);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int DW   = $clog2(DEBOUNCE + 1);
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE - 1);
  // Down-counter reloads: expiry at 1 puts the next FIRE exactly D cycles on.
  localparam logic [RW-1:0] RD_LD    = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_LD    = RW'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {IDLE, DEB_PRESS, FIRE, HOLD, DEB_REL} state_t;

  state_t          state, state_nx;
  logic            s1, btn_s;
  logic [DW-1:0]   dcnt, dcnt_nx;
  logic [RW-1:0]   rcnt, rcnt_nx;
  logic            rep, rep_nx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= 1'b0;
      btn_s <= 1'b0;
      state <= IDLE;
      dcnt  <= '0;
      rcnt  <= '0;
      rep   <= 1'b0;
    end else begin
      s1    <= btn;
      btn_s <= s1;
      state <= state_nx;
      dcnt  <= dcnt_nx;
      rcnt  <= rcnt_nx;
      rep   <= rep_nx;
    end
  end

  always_comb begin
    state_nx = state;
    dcnt_nx  = dcnt;
    rcnt_nx  = rcnt;
    rep_nx   = rep;
    case (state)
      IDLE: if (btn_s) begin
        state_nx = DEB_PRESS;
        dcnt_nx  = '0;
      end
      DEB_PRESS: begin
        if (!btn_s) state_nx = IDLE;
        else if (dcnt == DEB_LAST) begin
          state_nx = FIRE;
          rep_nx   = 1'b0;
        end else dcnt_nx = dcnt + DW'(1);
      end
      FIRE: begin
        state_nx = HOLD;
        rcnt_nx  = rep ? RP_LD : RD_LD;
      end
      HOLD: begin
        // Release beats a due repeat.
        if (!btn_s) begin
          state_nx = DEB_REL;
          dcnt_nx  = '0;
        end else if (!repeat_en) rcnt_nx = RD_LD;
        else if (rcnt == RW'(1)) begin
          state_nx = FIRE;
          rep_nx   = 1'b1;
        end else rcnt_nx = rcnt - RW'(1);
      end
      DEB_REL: begin
        if (btn_s) begin
          state_nx = HOLD;
          rcnt_nx  = RP_LD;
        end else if (dcnt == DEB_LAST) state_nx = IDLE;
        else dcnt_nx = dcnt + DW'(1);
      end
      default: state_nx = IDLE;
    endcase
  end

  assign pulse = (state == FIRE);
  assign held  = (state == FIRE) || (state == HOLD) || (state == DEB_REL);
endmodule

module multi_pulser #(
  parameter int N             = 4,
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_DELAY  = 20,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic         clk,
  input  logic         rst,
  multi_pulser_if.slave bus
);
  logic [N-1:0] pulse_v;
  logic [N-1:0] held_v;

  for (genvar g = 0; g < N; g++) begin : g_ch
    multi_pulser_chan #(
      .DEBOUNCE     (DEBOUNCE),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn      (bus.btn[g]),
      .repeat_en(bus.repeat_en[g]),
      .pulse    (pulse_v[g]),
      .held     (held_v[g])
    );
  end

  assign bus.pulse     = pulse_v;
  assign bus.held      = held_v;
  assign bus.any_pulse = |pulse_v;
endmodule

// File: tb/tb_multi_pulser.sv
// Bench for multi_pulser: vector table, directed corner sequences and a
// random phase scored against a run-length/timestamp reference model.
module tb_multi_pulser;
  localparam int N = 4, DEB = 4, RD = 20, RP = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  multi_pulser_if #(.N(N)) bus ();
  multi_pulser #(.N(N), .DEBOUNCE(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, want, $time);
  endtask

  // Reference model: a press is accepted after DEB+1 consecutive synced highs,
  // a release after DEB+1 consecutive synced lows; repeats are timestamped.
  logic [N-1:0] m_s1, m_bs, m_fire, m_held;
  int m_r[N], m_z[N], m_due[N];
  int cyc = 0;

  task automatic model_reset();
    m_s1 = '0; m_bs = '0; m_fire = '0; m_held = '0;
    for (int i = 0; i < N; i++) begin m_r[i] = 0; m_z[i] = 0; m_due[i] = 0; end
  endtask

  task automatic model_edge();
    if (!rst) begin model_reset(); return; end
    for (int i = 0; i < N; i++) begin
      if (m_fire[i]) begin
        m_fire[i] = 1'b0; m_z[i] = 0;
      end else if (!m_held[i]) begin
        if (m_bs[i]) begin
          m_r[i]++;
          if (m_r[i] == DEB + 1) begin
            m_fire[i] = 1'b1; m_held[i] = 1'b1; m_r[i] = 0; m_due[i] = cyc + 1 + RD;
          end
        end else m_r[i] = 0;
      end else if (!m_bs[i]) begin
        m_z[i]++;
        if (m_z[i] == DEB + 1) begin m_held[i] = 1'b0; m_z[i] = 0; end
      end else if (m_z[i] > 0) begin
        m_z[i] = 0; m_due[i] = cyc + RP;
      end else if (!bus.repeat_en[i]) m_due[i] = cyc + RD;
      else if (m_due[i] == cyc + 1) begin
        m_fire[i] = 1'b1; m_due[i] = cyc + 1 + RP;
      end
    end
    m_bs = m_s1;
    m_s1 = bus.btn;
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model", {bus.pulse, bus.held, bus.any_pulse}, {m_fire, m_held, |m_fire});
  endtask

  typedef struct { logic [N-1:0] btn, ren, pulse, held; } vec_t;
  vec_t tbl[16];

  int tp, k, npulse;
  bit ok;
  int offs[$];
  int exp_off[7] = '{0, 20, 28, 36, 44, 52, 60};
  int bounce[9]  = '{1, 1, 1, 0, 1, 1, 1, 0, 0};
  int dur[N];

  initial begin
    // Simultaneous press of all channels, then release.
    for (int i = 0; i < 16; i++)
      tbl[i] = '{(i < 8) ? 4'hF : 4'h0, 4'h0, (i == 6) ? 4'hF : 4'h0,
                 (i >= 6 && i < 14) ? 4'hF : 4'h0};

    bus.btn = '0; bus.repeat_en = '0;
    model_reset();
    tick(); tick();
    chk("reset_out", {bus.pulse, bus.held, bus.any_pulse}, '0);
    rst = 1'b1;
    tick(); tick();

    for (int i = 0; i < 16; i++) begin
      bus.btn = tbl[i].btn; bus.repeat_en = tbl[i].ren;
      tick();
      chk("tbl_pulse", bus.pulse, tbl[i].pulse);
      chk("tbl_held", bus.held, tbl[i].held);
      chk("tbl_any", bus.any_pulse, |tbl[i].pulse);
    end
    tick(); tick();

    // Bounce on channel 1.
    npulse = 0;
    foreach (bounce[i]) begin
      bus.btn[1] = bounce[i][0];
      tick();
      if (bus.pulse[1]) npulse++;
    end
    bus.btn[1] = 1'b1;
    k = 0;
    for (int t = 0; t < 20; t++) begin
      tick(); k++;
      if (bus.pulse[1]) break;
    end
    chk("bounce_quiet", npulse, 0);
    chk("bounce_lat", k, 7);
    bus.btn[1] = 1'b0;
    repeat (12) tick();
    chk("bounce_rel", bus.held[1], 1'b0);

    // Auto-repeat on channel 2.
    bus.repeat_en = 4'b0100; bus.btn = 4'b0100;
    tp = -1;
    for (int t = 0; t < 120; t++) begin
      tick();
      if (bus.pulse[2]) begin
        if (tp < 0) tp = t;
        offs.push_back(t - tp);
      end
      if (tp >= 0 && t - tp == 63) bus.btn[2] = 1'b0;
    end
    chk("rep_count", offs.size(), 7);
    for (int i = 0; i < 7; i++)
      chk("rep_offset", (i < offs.size()) ? offs[i] : -1, exp_off[i]);
    chk("rep_rel", bus.held[2], 1'b0);
    bus.repeat_en = '0;

    // Release glitch on channel 3.
    bus.btn = 4'b1000;
    repeat (10) tick();
    ok = bus.held[3];
    bus.btn[3] = 1'b0;
    for (int t = 0; t < 22; t++) begin
      if (t == 2) bus.btn[3] = 1'b1;
      tick();
      if (bus.pulse[3] || !bus.held[3]) ok = 1'b0;
    end
    chk("glitch_hold", ok, 1'b1);
    bus.btn = '0;
    repeat (12) tick();
    chk("glitch_rel", bus.held[3], 1'b0);

    // Reset while channel 0 is held.
    bus.btn = 4'b0001;
    repeat (10) tick();
    chk("pre_rst_held", bus.held[0], 1'b1);
    #2; rst = 1'b0; model_reset();
    #1;
    chk("rst_imm", {bus.pulse, bus.held, bus.any_pulse}, '0);
    tick(); tick();
    rst = 1'b1;
    k = 0;
    for (int t = 0; t < 20; t++) begin
      tick(); k++;
      if (bus.pulse[0]) break;
    end
    chk("rst_repulse", k, 7);
    bus.btn = '0;
    repeat (12) tick();

    // Random phase against the model.
    for (int i = 0; i < N; i++) dur[i] = 0;
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < N; i++) begin
        if (dur[i] == 0) begin
          bus.btn[i] = ~bus.btn[i];
          dur[i] = ($urandom_range(0, 9) < 3) ? $urandom_range(1, 5) : $urandom_range(6, 60);
        end else dur[i]--;
      end
      if ($urandom_range(0, 49) == 0) bus.repeat_en[$urandom_range(0, N - 1)] ^= 1'b1;
      tick();
    end
    bus.btn = '0;
    repeat (12) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
